// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequencer for the two-stage line-buffer chain ahead of the
// 3x3 matrix generator. It tracks the frame position of the incoming pixel
// stream and writes each pixel into the chain. Each vertical tap triplet is
// tagged with its centre-row/column and border flags.
//
// Build option: define LB_FLUSH_EN to add a dummy flush row at end of frame.
// The flush row lets the last image row reach the matrix generator as a centre
// row. Without it, the final centre row is never emitted and ready stays high.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   din, valid_in     input pixel and its valid strobe
//   sof               start of frame, qualified by valid_in
//   ready             block can accept a pixel (combinational from state)
//   lb_din, lb_wr_en  data and write strobe to the line-buffer chain
//   lb_clr            one-cycle clear pulse to the chain after a mid-frame sof
//   col_valid         vertical tap triplet valid
//   col_row, col_col  centre row / column of the current triplet
//   border            {top, bottom, left, right} flags of the centre pixel
//   frame_done        one-cycle pulse with the last triplet of a frame
//   sof_err           sticky mid-frame sof flag, cleared only by reset
module line_buffer_ctrl #(
   parameter int unsigned WIDTH      = 10,
   parameter int unsigned IMG_WIDTH  = 480,
   parameter int unsigned IMG_HEIGHT = 272,
   parameter int unsigned CW         = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             valid_in,
   input  logic             sof,
   output logic             ready,
   output logic [WIDTH-1:0] lb_din,
   output logic             lb_wr_en,
   output logic             lb_clr,
   output logic             col_valid,
   output logic [CW-1:0]    col_row,
   output logic [CW-1:0]    col_col,
   output logic [3:0]       border,
   output logic             frame_done,
   output logic             sof_err
);

   localparam logic [CW-1:0] LastCol = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] LastRow = CW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] One     = CW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StFirst,
`ifdef LB_FLUSH_EN
      StRun,
      StFlush
`else
      StRun
`endif
   } state_e;

   state_e state_q, state_d;

   // row_q/col_q hold the position of the next pixel expected in FIRST/RUN;
   // in FLUSH col_q walks the dummy row.
   logic [CW-1:0] row_q, row_d, col_q, col_d;

   logic [WIDTH-1:0] din_d;
   logic             wr_d, clr_d, cv_d, done_d, err_d;
   logic [CW-1:0]    crow_d, ccol_d;
   logic [3:0]       border_d;

   logic          accept, last_col, last_pix;
   logic [CW-1:0] row_above;

`ifdef LB_FLUSH_EN
   assign ready = (state_q != StFlush);
`else
   assign ready = 1'b1;
`endif

   assign accept    = valid_in && ready;
   assign last_col  = (col_q == LastCol);
   assign last_pix  = last_col && (row_q == LastRow);
   // Centre row of the triplet completed by the current pixel.
   assign row_above = row_q - One;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      din_d    = lb_din;
      wr_d     = 1'b0;
      clr_d    = 1'b0;
      cv_d     = 1'b0;
      crow_d   = col_row;
      ccol_d   = col_col;
      border_d = border;
      done_d   = 1'b0;
      err_d    = sof_err;

      unique case (state_q)
         StIdle: begin
            // Pixels without sof are dropped until a frame starts.
            if (accept && sof) begin
               wr_d    = 1'b1;
               din_d   = din;
               row_d   = '0;
               col_d   = One;
               state_d = StFirst;
            end
         end

         StFirst, StRun: begin
            if (accept && sof) begin
               // Mid-frame sof: drop the pixel, clear the chain and resync.
               err_d   = 1'b1;
               clr_d   = 1'b1;
               row_d   = '0;
               col_d   = '0;
               state_d = StIdle;
            end else if (accept) begin
               wr_d  = 1'b1;
               din_d = din;
               if (state_q == StRun) begin
                  cv_d     = 1'b1;
                  crow_d   = row_above;
                  ccol_d   = col_q;
                  border_d = {row_above == '0, row_above == LastRow, col_q == '0, last_col};
               end
               if (last_pix) begin
                  row_d = '0;
                  col_d = '0;
`ifdef LB_FLUSH_EN
                  state_d = StFlush;
`else
                  done_d  = 1'b1;
                  state_d = StIdle;
`endif
               end else if (last_col) begin
                  col_d   = '0;
                  row_d   = row_q + One;
                  state_d = StRun;
               end else begin
                  col_d = col_q + One;
               end
            end
         end

`ifdef LB_FLUSH_EN
         StFlush: begin
            // Zero row pushed through the chain so the last image row is centred.
            wr_d     = 1'b1;
            din_d    = '0;
            cv_d     = 1'b1;
            crow_d   = LastRow;
            ccol_d   = col_q;
            border_d = {LastRow == '0, 1'b1, col_q == '0, last_col};
            if (last_col) begin
               done_d  = 1'b1;
               col_d   = '0;
               state_d = StIdle;
            end else begin
               col_d = col_q + One;
            end
         end
`endif

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         row_q      <= '0;
         col_q      <= '0;
         lb_din     <= '0;
         lb_wr_en   <= 1'b0;
         lb_clr     <= 1'b0;
         col_valid  <= 1'b0;
         col_row    <= '0;
         col_col    <= '0;
         border     <= '0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         lb_din     <= din_d;
         lb_wr_en   <= wr_d;
         lb_clr     <= clr_d;
         col_valid  <= cv_d;
         col_row    <= crow_d;
         col_col    <= ccol_d;
         border     <= border_d;
         frame_done <= done_d;
         sof_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a 4x3 image. A frame-level model
// (pixel index arithmetic) predicts every output each cycle; literal checks per
// scenario pin cycle positions, counts and border codes.
module tb_line_buffer_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int DW = 10;
   localparam int CW = 4;
`ifdef LB_FLUSH_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          valid_in = 1'b0;
   logic          sof = 1'b0;
   logic          ready, lb_wr_en, lb_clr, col_valid, frame_done, sof_err;
   logic [DW-1:0] lb_din;
   logic [CW-1:0] col_row, col_col;
   logic [3:0]    border;

   line_buffer_ctrl #(.WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .valid_in(valid_in), .sof(sof),
      .ready(ready), .lb_din(lb_din), .lb_wr_en(lb_wr_en), .lb_clr(lb_clr),
      .col_valid(col_valid), .col_row(col_row), .col_col(col_col), .border(border),
      .frame_done(frame_done), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   // mode: 0 waiting for sof, 1 inside frame, 2 flushing dummy row.
   typedef struct {
      int            mode;
      int            idx;
      int            fl;
      logic          wr, cv, fd, clr, err;
      logic [DW-1:0] dn;
      int            row, col;
      logic [3:0]    bd;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t m_reset();
      mdl_t n;
      n.mode = 0; n.idx = 0; n.fl = 0;
      n.wr = 0; n.cv = 0; n.fd = 0; n.clr = 0; n.err = 0;
      n.dn = '0; n.row = 0; n.col = 0; n.bd = '0;
      return n;
   endfunction

   function automatic mdl_t emit(input mdl_t s, input int p, input logic [DW-1:0] d);
      mdl_t n;
      int r, c;
      n = s;
      r = p / W;
      c = p % W;
      n.wr = 1'b1;
      n.dn = d;
      if (r >= 1) begin
         n.cv  = 1'b1;
         n.row = r - 1;
         n.col = c;
         n.bd  = {(r - 1) == 0, (r - 1) == H - 1, c == 0, c == W - 1};
      end
      if (p == W * H - 1) begin
         n.mode = FL ? 2 : 0;
         n.fl   = 0;
         n.fd   = !FL;
      end else begin
         n.mode = 1;
         n.idx  = p + 1;
      end
      return n;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic v, input logic sf,
                                 input logic [DW-1:0] d);
      mdl_t n;
      n = s;
      n.wr = 0; n.cv = 0; n.fd = 0; n.clr = 0;
      if (s.mode == 2) begin
         n.wr  = 1'b1;
         n.dn  = '0;
         n.cv  = 1'b1;
         n.row = H - 1;
         n.col = s.fl;
         n.bd  = {1'b0, 1'b1, s.fl == 0, s.fl == W - 1};
         n.fl  = s.fl + 1;
         if (n.fl == W) begin
            n.fd   = 1'b1;
            n.mode = 0;
         end
      end else if (v === 1'b1) begin
         if (s.mode == 0) begin
            if (sf === 1'b1) n = emit(n, 0, d);
         end else if (sf === 1'b1) begin
            n.err  = 1'b1;
            n.clr  = 1'b1;
            n.mode = 0;
         end else begin
            n = emit(n, s.idx, d);
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= m_reset();
      else        m <= step(m, valid_in, sof, din);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("ready", ready, (m.mode != 2));
      chk("lb_wr_en", lb_wr_en, m.wr);
      chk("lb_clr", lb_clr, m.clr);
      chk("col_valid", col_valid, m.cv);
      chk("frame_done", frame_done, m.fd);
      chk("sof_err", sof_err, m.err);
      if (m.wr) chk("lb_din", lb_din, m.dn);
      if (m.cv) begin
         chk("col_row", col_row, m.row);
         chk("col_col", col_col, m.col);
         chk("border", border, m.bd);
      end
   end

   // ---------------- per-scenario recorder ----------------
   int cyc = 0;
   int c0 = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rec_cv[64], rec_wr[64], rec_fd[64], rec_clr[64], rec_rdy[64], rec_err[64];
   logic [CW-1:0] rec_row[64], rec_col[64];
   logic [3:0]    rec_bd[64];
   logic [DW-1:0] rec_din[64];

   always @(negedge clk) begin
      if (cyc - c0 >= 0 && cyc - c0 < 64) begin
         rec_cv[cyc-c0]  <= col_valid;
         rec_wr[cyc-c0]  <= lb_wr_en;
         rec_fd[cyc-c0]  <= frame_done;
         rec_clr[cyc-c0] <= lb_clr;
         rec_rdy[cyc-c0] <= ready;
         rec_err[cyc-c0] <= sof_err;
         rec_row[cyc-c0] <= col_row;
         rec_col[cyc-c0] <= col_col;
         rec_bd[cyc-c0]  <= border;
         rec_din[cyc-c0] <= lb_din;
      end
   end

   // sel: 0 col_valid, 1 lb_wr_en, 2 frame_done, 3 lb_clr, 4 ready low
   function automatic int cnt(input int sel, input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) begin
         case (sel)
            0: n += int'(rec_cv[i]);
            1: n += int'(rec_wr[i]);
            2: n += int'(rec_fd[i]);
            3: n += int'(rec_clr[i]);
            default: n += int'(!rec_rdy[i]);
         endcase
      end
      return n;
   endfunction

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input logic v, input logic s, input logic [DW-1:0] d);
      valid_in = v;
      sof      = s;
      din      = d;
      tick();
   endtask

   task automatic finish_rec();
      valid_in = 1'b0;
      sof      = 1'b0;
      while (cyc - c0 < 66) tick();
   endtask

   localparam int FullCv = FL ? 12 : 8;
   localparam int LastT  = FL ? 16 : 12;

   initial begin
      int bad;
      repeat (3) tick();
      chk("rst_ready_low", ready, 1);
      chk("rst_col_valid", col_valid, 0);
      rst_n = 1'b1;
      tick();
      chk("reset_ready", ready, 1);
      chk("reset_wr", lb_wr_en, 0);
      chk("reset_cv", col_valid, 0);
      chk("reset_err", sof_err, 0);
      chk("reset_border", border, 0);

      // S1: back-to-back frame
      c0 = cyc;
      for (int p = 0; p < 12; p++) px(1'b1, p == 0, DW'(p * 7 + 1));
      finish_rec();
      chk("s1_cv4", rec_cv[4], 0);
      chk("s1_cv5", rec_cv[5], 1);
      chk("s1_first_row", rec_row[5], 0);
      chk("s1_first_col", rec_col[5], 0);
      chk("s1_first_border", rec_bd[5], 4'b1010);
      chk("s1_cv_count", cnt(0, 0, 63), FullCv);
      chk("s1_last_cv", rec_cv[LastT], 1);
      chk("s1_after_last_cv", rec_cv[LastT+1], 0);
      chk("s1_last_row", rec_row[LastT], FL ? 2 : 1);
      chk("s1_last_col", rec_col[LastT], 3);
      chk("s1_last_border", rec_bd[LastT], FL ? 4'b0101 : 4'b0001);
      chk("s1_done_at_last", rec_fd[LastT], 1);
      chk("s1_done_count", cnt(2, 0, 63), 1);
      chk("s1_ready_low_count", cnt(4, 0, 63), FL ? 4 : 0);
      chk("s1_ready12", rec_rdy[12], FL ? 0 : 1);
      chk("s1_ready16", rec_rdy[16], 1);
      chk("s1_wr_count", cnt(1, 0, 63), FL ? 16 : 12);
      chk("s1_din1", rec_din[1], 1);
      chk("s1_din13", rec_din[13], FL ? 0 : 78);

      // S2: gap after every pixel
      c0 = cyc;
      for (int p = 0; p < 12; p++) begin
         px(1'b1, p == 0, DW'(p + 100));
         px(1'b0, 1'b0, '0);
      end
      finish_rec();
      chk("s2_wr1", rec_wr[1], 1);
      chk("s2_gap_wr2", rec_wr[2], 0);
      chk("s2_cv9", rec_cv[9], 1);
      chk("s2_cv_count", cnt(0, 0, 63), FullCv);
      chk("s2_wr_count", cnt(1, 0, 63), FL ? 16 : 12);
      chk("s2_done_count", cnt(2, 0, 63), 1);
      bad = 0;
      begin
         int k = 0;
         for (int i = 0; i < 64; i++) begin
            if (rec_cv[i]) begin
               if (int'(rec_row[i]) != k / W || int'(rec_col[i]) != k % W) bad++;
               k++;
            end
         end
      end
      chk("s2_coord_sequence", bad, 0);

      // S3: valid without sof is ignored until sof
      c0 = cyc;
      for (int i = 0; i < 5; i++) px(1'b1, 1'b0, DW'(500 + i));
      for (int p = 0; p < 12; p++) px(1'b1, p == 0, DW'(p + 33));
      finish_rec();
      chk("s3_no_wr_before_sof", cnt(1, 0, 5), 0);
      chk("s3_wr6", rec_wr[6], 1);
      chk("s3_din6", rec_din[6], 33);
      chk("s3_first_cv_row", rec_row[10], 0);
      chk("s3_first_cv_border", rec_bd[10], 4'b1010);
      chk("s3_cv_count", cnt(0, 0, 63), FullCv);

      // S4: mid-frame sof at pixel 6, then a clean frame
      c0 = cyc;
      for (int p = 0; p < 6; p++) px(1'b1, p == 0, DW'(p + 200));
      px(1'b1, 1'b1, DW'(999));
      px(1'b0, 1'b0, '0);
      px(1'b0, 1'b0, '0);
      for (int p = 0; p < 12; p++) px(1'b1, p == 0, DW'(p + 300));
      finish_rec();
      chk("s4_clr7", rec_clr[7], 1);
      chk("s4_clr_count", cnt(3, 0, 63), 1);
      chk("s4_wr7", rec_wr[7], 0);
      chk("s4_err7", rec_err[7], 1);
      chk("s4_err_sticky", rec_err[63], 1);
      chk("s4_next_frame_cv", cnt(0, 9, 63), FullCv);
      chk("s4_done_count", cnt(2, 0, 63), 1);

      // S7: sof on the final pixel counts as mid-frame
      c0 = cyc;
      for (int p = 0; p < 11; p++) px(1'b1, p == 0, DW'(p + 400));
      px(1'b1, 1'b1, DW'(411));
      finish_rec();
      chk("s7_cv_count", cnt(0, 0, 63), 7);
      chk("s7_wr_count", cnt(1, 0, 63), 11);
      chk("s7_no_done", cnt(2, 0, 63), 0);
      chk("s7_clr12", rec_clr[12], 1);
      chk("s7_no_flush", cnt(4, 0, 63), 0);

      // S5: asynchronous reset mid-RUN
      c0 = cyc;
      for (int p = 0; p < 6; p++) px(1'b1, p == 0, DW'(p + 600));
      valid_in = 1'b0;
      sof      = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("s5_async_cv", col_valid, 0);
      chk("s5_async_wr", lb_wr_en, 0);
      chk("s5_async_ready", ready, 1);
      chk("s5_async_row", col_row, 0);
      chk("s5_async_err", sof_err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      for (int p = 0; p < 12; p++) px(1'b1, p == 0, DW'(p + 700));
      finish_rec();
      chk("s5_cv_after_reset", cnt(0, 8, 63), FullCv);
      chk("s5_done_count", cnt(2, 0, 63), 1);
      chk("s5_no_clr", cnt(3, 0, 63), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
